// File: rtl/frame_buffer_renderer.sv
// ============================================================================
// frame_buffer_renderer
//
// Double-buffered RGB565 frame buffer with a display read path and a
// producer write path.
//
// A producer streams pixels into the back bank over a valid/ready handshake.
// The display side presents hcount/vcount and receives registered RGB565
// exactly two cycles later. The display position can be integer-upscaled,
// and any position outside the image returns a fixed background colour.
// Banks swap only on a display frame boundary, and only once the back bank
// holds a complete frame, so a partially written frame is never shown.
//
// Ports:
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   x_in, y_in       display hcount / vcount
//   frame_start_in   one-cycle pulse at the display frame boundary
//   wr_valid_in      producer pixel valid
//   wr_data_in       producer pixel, RGB565 {r[15:11], g[10:5], b[4:0]}
//   wr_last_in       final pixel of the producer frame
//   wr_ready_out     block can accept a pixel (registered, FILL state)
//   r_out/g_out/b_out  display colour, two cycles after x_in/y_in
//   swap_out         one-cycle pulse when the banks swap
//   frame_count_out  number of swaps since reset, wraps 255 -> 0
// ============================================================================
module frame_buffer_renderer #(
    parameter int unsigned H_RES       = 4,
    parameter int unsigned V_RES       = 2,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter logic [15:0] BG_COLOR    = 16'h0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        frame_start_in,
    input  logic        wr_valid_in,
    input  logic [15:0] wr_data_in,
    input  logic        wr_last_in,
    output logic        wr_ready_out,
    output logic [4:0]  r_out,
    output logic [5:0]  g_out,
    output logic [4:0]  b_out,
    output logic        swap_out,
    output logic [7:0]  frame_count_out
);

    localparam int unsigned DEPTH = H_RES * V_RES;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Two banks; index 0/1 selected by front_sel_q on the read side and by
    // its complement on the write side. Contents survive reset on purpose.
    logic [15:0] mem_q [2][DEPTH];

    state_e        state_q;
    logic [AW-1:0] wr_addr_q;
    logic          wr_ready_q;
    logic          front_sel_q;
    logic          swap_q;
    logic [7:0]    frame_count_q;

    logic [10:0]   sx_d;
    logic [9:0]    sy_d;
    logic          oob_d;
    logic [AW-1:0] addr_d;

    logic          oob1_q;
    logic [AW-1:0] addr1_q;
    logic          sel1_q;
    logic [15:0]   pix_q;

    logic          wr_fire;

    assign wr_fire = wr_valid_in && wr_ready_q;

    // Stage 1 combinational address generation. The linear address is
    // formed in 32 bits and truncated; it is only meaningful when in bounds.
    assign sx_d   = x_in >> SCALE_SHIFT;
    assign sy_d   = y_in >> SCALE_SHIFT;
    assign oob_d  = (32'(sx_d) >= H_RES) || (32'(sy_d) >= V_RES);
    assign addr_d = AW'(32'(sx_d) + 32'(sy_d) * H_RES);

    // Back-bank write port. Gated by rst_n_in so an edge arriving while
    // reset is held never lands a stray pixel.
    always_ff @(posedge clk_in) begin
        if (wr_fire && rst_n_in) begin
            mem_q[~front_sel_q][wr_addr_q] <= wr_data_in;
        end
    end

    // Two-stage read pipeline: stage 1 captures address, bounds flag and
    // the bank to read; stage 2 performs the lookup or substitutes BG_COLOR.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            oob1_q  <= 1'b0;
            addr1_q <= '0;
            sel1_q  <= 1'b0;
            pix_q   <= 16'h0000;
        end else begin
            oob1_q  <= oob_d;
            addr1_q <= addr_d;
            sel1_q  <= front_sel_q;
            pix_q   <= oob1_q ? BG_COLOR : mem_q[sel1_q][addr1_q];
        end
    end

    // Writer FSM. FILL accepts pixels until last (explicit or implied by the
    // final address); FULL waits for a display frame boundary to swap.
    // A frame boundary seen while still filling is ignored, so the old
    // front bank is simply displayed again.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= FILL;
            wr_addr_q     <= '0;
            wr_ready_q    <= 1'b1;
            front_sel_q   <= 1'b0;
            swap_q        <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            swap_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (wr_fire) begin
                        if (wr_last_in || (wr_addr_q == LAST_ADDR)) begin
                            state_q    <= FULL;
                            wr_addr_q  <= '0;
                            wr_ready_q <= 1'b0;
                        end else begin
                            wr_addr_q <= wr_addr_q + AW'(1);
                        end
                    end
                end
                FULL: begin
                    if (frame_start_in) begin
                        front_sel_q   <= ~front_sel_q;
                        swap_q        <= 1'b1;
                        frame_count_q <= frame_count_q + 8'd1;
                        state_q       <= FILL;
                        wr_ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign wr_ready_out    = wr_ready_q;
    assign swap_out        = swap_q;
    assign frame_count_out = frame_count_q;
    assign r_out           = pix_q[15:11];
    assign g_out           = pix_q[10:5];
    assign b_out           = pix_q[4:0];

endmodule

// File: tb/tb_frame_buffer_renderer.sv
// ============================================================================
// tb_frame_buffer_renderer
//
// Two instances share every input: dut0 is unscaled, dut1 upscales by 2.
// Both use a red background so out-of-bounds reads are distinguishable from
// black pixels. Display reads push their expected pixel into a scoreboard
// queue tagged with the cycle on which the result must appear.
// ============================================================================
module tb_frame_buffer_renderer;

    logic        clk;
    logic        rstN;
    logic [10:0] xIn;
    logic [9:0]  yIn;
    logic        frameStart;
    logic        wrValid;
    logic [15:0] wrData;
    logic        wrLast;

    logic        wrReady0, swap0, wrReady1, swap1;
    logic [4:0]  r0, b0, r1, b1;
    logic [5:0]  g0, g1;
    logic [7:0]  count0, count1;

    frame_buffer_renderer #(
        .H_RES(4), .V_RES(2), .SCALE_SHIFT(0), .BG_COLOR(16'hF800)
    ) dut0 (
        .clk_in(clk), .rst_n_in(rstN), .x_in(xIn), .y_in(yIn),
        .frame_start_in(frameStart), .wr_valid_in(wrValid),
        .wr_data_in(wrData), .wr_last_in(wrLast), .wr_ready_out(wrReady0),
        .r_out(r0), .g_out(g0), .b_out(b0), .swap_out(swap0),
        .frame_count_out(count0)
    );

    frame_buffer_renderer #(
        .H_RES(4), .V_RES(2), .SCALE_SHIFT(1), .BG_COLOR(16'hF800)
    ) dut1 (
        .clk_in(clk), .rst_n_in(rstN), .x_in(xIn), .y_in(yIn),
        .frame_start_in(frameStart), .wr_valid_in(wrValid),
        .wr_data_in(wrData), .wr_last_in(wrLast), .wr_ready_out(wrReady1),
        .r_out(r1), .g_out(g1), .b_out(b1), .swap_out(swap1),
        .frame_count_out(count1)
    );

    typedef struct {
        string       name;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic        chk1;
        int          due;
    } sbEntry_t;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    sbEntry_t sbQ[$];
    vec_t     vecs[14];

    int checks   = 0;
    int errors   = 0;
    int cycleNum = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h",
                     name, cycleNum, actual, expected);
        end
    endtask

    // Advance one clock and retire any scoreboard entries due this cycle.
    task automatic tick();
        sbEntry_t e;
        @(posedge clk);
        #1;
        cycleNum++;
        while (sbQ.size() > 0 && sbQ[0].due <= cycleNum) begin
            e = sbQ.pop_front();
            checkOutput({e.name, "_dut0"}, {16'h0, r0, g0, b0}, {16'h0, e.exp0});
            if (e.chk1) begin
                checkOutput({e.name, "_dut1"}, {16'h0, r1, g1, b1}, {16'h0, e.exp1});
            end
        end
    endtask

    // Present one display coordinate; its result is due two edges later.
    task automatic applyStimulus(input vec_t v);
        sbEntry_t e;
        xIn    = v.x;
        yIn    = v.y;
        e.name = "scan";
        e.exp0 = v.exp0;
        e.exp1 = v.exp1;
        e.chk1 = 1'b1;
        e.due  = cycleNum + 2;
        sbQ.push_back(e);
        tick();
    endtask

    task automatic readPix(input string name, input logic [10:0] x,
                           input logic [9:0] y, input logic [15:0] exp0);
        sbEntry_t e;
        xIn    = x;
        yIn    = y;
        e.name = name;
        e.exp0 = exp0;
        e.exp1 = 16'h0;
        e.chk1 = 1'b0;
        e.due  = cycleNum + 2;
        sbQ.push_back(e);
        tick();
    endtask

    task automatic drain();
        tick();
        tick();
    endtask

    task automatic writePixel(input logic [15:0] data, input logic last);
        wrValid = 1'b1;
        wrData  = data;
        wrLast  = last;
        tick();
        wrValid = 1'b0;
        wrLast  = 1'b0;
    endtask

    task automatic pulseFrameStart();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    initial begin
        // x/y -> {unscaled pixel, 2x-upscaled pixel} for frame A = 0..7
        vecs[0]  = '{11'd0,    10'd0,    16'd0,     16'd0};
        vecs[1]  = '{11'd1,    10'd0,    16'd1,     16'd0};
        vecs[2]  = '{11'd2,    10'd0,    16'd2,     16'd1};
        vecs[3]  = '{11'd3,    10'd0,    16'd3,     16'd1};
        vecs[4]  = '{11'd0,    10'd1,    16'd4,     16'd0};
        vecs[5]  = '{11'd3,    10'd1,    16'd7,     16'd1};
        vecs[6]  = '{11'd4,    10'd0,    16'hF800,  16'd2};
        vecs[7]  = '{11'd0,    10'd2,    16'hF800,  16'd4};
        vecs[8]  = '{11'd7,    10'd3,    16'hF800,  16'd7};
        vecs[9]  = '{11'd8,    10'd0,    16'hF800,  16'hF800};
        vecs[10] = '{11'd2,    10'd1,    16'd6,     16'd1};
        vecs[11] = '{11'd5,    10'd2,    16'hF800,  16'd6};
        vecs[12] = '{11'd0,    10'd4,    16'hF800,  16'hF800};
        vecs[13] = '{11'd2047, 10'd1023, 16'hF800,  16'hF800};

        rstN       = 1'b0;
        xIn        = '0;
        yIn        = '0;
        frameStart = 1'b0;
        wrValid    = 1'b0;
        wrData     = '0;
        wrLast     = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("reset_rgb", {16'h0, r0, g0, b0}, 32'h0);
        checkOutput("reset_ready", {31'h0, wrReady0}, 32'd1);
        checkOutput("reset_swap", {31'h0, swap0}, 32'd0);
        checkOutput("reset_count", {24'h0, count0}, 32'd0);
        rstN = 1'b1;
        tick();

        // Fill frame A with 0..7, last on 7
        for (int i = 0; i < 8; i++) begin
            writePixel(16'(i), i == 7);
            checkOutput("fill_ready", {31'h0, wrReady0}, (i == 7) ? 32'd0 : 32'd1);
        end
        writePixel(16'hDEAD, 1'b0);
        checkOutput("full_ready_held", {31'h0, wrReady0}, 32'd0);
        checkOutput("full_no_swap", {31'h0, swap0}, 32'd0);
        pulseFrameStart();
        checkOutput("swapA_pulse", {31'h0, swap0}, 32'd1);
        checkOutput("swapA_count", {24'h0, count0}, 32'd1);
        checkOutput("swapA_count_dut1", {24'h0, count1}, 32'd1);
        checkOutput("swapA_ready", {31'h0, wrReady0}, 32'd1);
        tick();
        checkOutput("swapA_pulse_end", {31'h0, swap0}, 32'd0);

        // Back-to-back scan through the vector table, both scale factors
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
        end
        drain();

        // No tearing: frame B written while A is displayed
        for (int i = 0; i < 3; i++) writePixel(16'hFFFF, 1'b0);
        pulseFrameStart();
        checkOutput("midfill_no_swap", {31'h0, swap0}, 32'd0);
        checkOutput("midfill_count", {24'h0, count0}, 32'd1);
        checkOutput("midfill_ready", {31'h0, wrReady0}, 32'd1);
        readPix("tear_a7", 11'd3, 10'd1, 16'd7);
        readPix("tear_a0", 11'd0, 10'd0, 16'd0);
        drain();
        for (int i = 0; i < 4; i++) writePixel(16'hFFFF, 1'b0);
        readPix("tear_a2", 11'd2, 10'd0, 16'd2);
        drain();
        // Final pixel with last coinciding with a frame boundary
        wrValid    = 1'b1;
        wrData     = 16'hFFFF;
        wrLast     = 1'b1;
        frameStart = 1'b1;
        tick();
        wrValid    = 1'b0;
        wrLast     = 1'b0;
        frameStart = 1'b0;
        checkOutput("lastfs_no_swap", {31'h0, swap0}, 32'd0);
        checkOutput("lastfs_ready", {31'h0, wrReady0}, 32'd0);
        checkOutput("lastfs_count", {24'h0, count0}, 32'd1);
        readPix("tear_a5", 11'd1, 10'd1, 16'd5);
        drain();
        pulseFrameStart();
        checkOutput("swapB_pulse", {31'h0, swap0}, 32'd1);
        checkOutput("swapB_count", {24'h0, count0}, 32'd2);
        readPix("b_px0", 11'd0, 10'd0, 16'hFFFF);
        readPix("b_px7", 11'd3, 10'd1, 16'hFFFF);
        readPix("b_px6", 11'd2, 10'd1, 16'hFFFF);
        drain();

        // Short frame: last on the 3rd pixel, rest of the bank keeps frame A
        writePixel(16'h0100, 1'b0);
        writePixel(16'h0101, 1'b0);
        checkOutput("short_ready2", {31'h0, wrReady0}, 32'd1);
        writePixel(16'h0102, 1'b1);
        checkOutput("short_ready3", {31'h0, wrReady0}, 32'd0);
        pulseFrameStart();
        checkOutput("short_count", {24'h0, count0}, 32'd3);
        readPix("short_px0", 11'd0, 10'd0, 16'h0100);
        readPix("short_px2", 11'd2, 10'd0, 16'h0102);
        readPix("short_px3", 11'd3, 10'd0, 16'd3);
        readPix("short_px4", 11'd0, 10'd1, 16'd4);
        readPix("short_px7", 11'd3, 10'd1, 16'd7);
        drain();

        // Auto-last: eight pixels with no last flag
        for (int i = 0; i < 8; i++) begin
            writePixel(16'h1000 + 16'(i), 1'b0);
            checkOutput("auto_ready", {31'h0, wrReady0}, (i == 7) ? 32'd0 : 32'd1);
        end
        pulseFrameStart();
        checkOutput("auto_count", {24'h0, count0}, 32'd4);
        readPix("auto_px0", 11'd0, 10'd0, 16'h1000);
        readPix("auto_px7", 11'd3, 10'd1, 16'h1007);
        readPix("auto_px1", 11'd1, 10'd0, 16'h1001);
        drain();

        // Async reset after five writes, asserted between clock edges
        for (int i = 0; i < 5; i++) writePixel(16'h2000 + 16'(i), 1'b0);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("arst_rgb", {16'h0, r0, g0, b0}, 32'h0);
        checkOutput("arst_count", {24'h0, count0}, 32'd0);
        checkOutput("arst_swap", {31'h0, swap0}, 32'd0);
        sbQ.delete();
        tick();
        rstN = 1'b1;
        tick();
        checkOutput("arst_ready_after", {31'h0, wrReady0}, 32'd1);
        checkOutput("arst_count_after", {24'h0, count0}, 32'd0);
        readPix("arst_retained", 11'd1, 10'd0, 16'h1001);
        drain();
        for (int i = 0; i < 8; i++) begin
            writePixel(16'h3000 + 16'(i), i == 7);
            checkOutput("arst_fill_ready", {31'h0, wrReady0}, (i == 7) ? 32'd0 : 32'd1);
        end
        pulseFrameStart();
        checkOutput("arst_swap_pulse", {31'h0, swap0}, 32'd1);
        checkOutput("arst_swap_count", {24'h0, count0}, 32'd1);
        readPix("arst_px0", 11'd0, 10'd0, 16'h3000);
        readPix("arst_px5", 11'd1, 10'd1, 16'h3005);
        readPix("arst_px7", 11'd3, 10'd1, 16'h3007);
        drain();

        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_renderer.md
Name: frame_buffer_renderer

Overview:
- Parametrised, double-buffered successor to the fixed-size 3D renderer pixel lookup.
- A producer (ray tracer / rasteriser) streams RGB565 pixels into a back buffer over a valid/ready handshake.
- The display side supplies hcount/vcount and gets registered RGB565 with fixed latency, optional integer upscaling and background fill outside the image.
- Buffers swap only at a frame boundary, and only once the back buffer is complete, so no tearing is visible.

Parameters:
- H_RES, 4: image width in source pixels.
- V_RES, 2: image height in source pixels.
- SCALE_SHIFT, 0: display upscaling; each source pixel covers a 2^SCALE_SHIFT x 2^SCALE_SHIFT block of screen pixels.
- BG_COLOR, 16'h0000: RGB565 value output outside the image.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- x_in  input  11  display hcount
- y_in  input  10  display vcount
- frame_start_in  input  1  one-cycle pulse marking display frame boundary
- wr_valid_in  input  1  producer pixel valid
- wr_data_in  input  16  producer pixel, RGB565 {r[15:11], g[10:5], b[4:0]}
- wr_last_in  input  1  marks final pixel of producer frame
- wr_ready_out  output  1  block can accept a pixel
- r_out  output  5  red
- g_out  output  6  green
- b_out  output  5  blue
- swap_out  output  1  one-cycle pulse: buffers swapped
- frame_count_out  output  8  number of swaps since reset, wraps 255->0

Behaviour:
- Storage: two banks of H_RES*V_RES x 16 bits; front_sel selects the displayed bank; the writer fills bank !front_sel. Bank contents are not cleared by reset.
- Reset (async assert, sync release):
  - front_sel=0, state=FILL, wr_addr=0, frame_count_out=0, swap_out=0.
  - r/g/b_out=0; pipeline registers cleared.
  - Reset mid-write discards the partial frame; bank contents are retained.
- Read pipeline, latency exactly 2 cycles from x_in/y_in to r/g/b_out:
  - Stage 1 registers:
    - sx = x_in >> SCALE_SHIFT, sy = y_in >> SCALE_SHIFT.
    - oob = (sx >= H_RES) || (sy >= V_RES).
    - addr = sx + sy*H_RES, computed in width ceil(log2(H_RES*V_RES)).
    - Current front_sel.
  - Stage 2 registers oob ? BG_COLOR : bank[sel][addr], split into r/g/b.
  - A new address is accepted every cycle; there are no bubbles.
- Write state machine:
  - FILL:
    - wr_ready_out=1.
    - A handshake (wr_valid_in && wr_ready_out) writes wr_data_in to back[wr_addr]; wr_addr increments.
    - If wr_last_in is high, or wr_addr == H_RES*V_RES-1, on that handshake: go to FULL and set wr_addr=0.
    - A short frame (early last) leaves the untouched locations holding their previous contents.
  - FULL:
    - wr_ready_out=0; writes are ignored.
    - On frame_start_in: front_sel toggles, swap_out=1 for one cycle, frame_count_out increments, state returns to FILL.
    - The new front_sel is used by stage 1 from the cycle after frame_start_in.
- frame_start_in in FILL:
  - No swap; the front buffer is re-displayed.
  - The writer continues uninterrupted.
- A handshake with last in the same cycle as frame_start_in (state FILL):
  - The handshake completes and the state becomes FULL.
  - No swap occurs until the next frame_start_in.
- wr_ready_out is a registered function of state; it never depends combinationally on wr_valid_in.
- A write to the back bank never aliases a front-bank read; a same-address read/write on different banks is independent.

Test Plan:
- Reset then fill: H_RES=4, V_RES=2, stream values 0..7 with wr_last on 7, pulse frame_start_in, then scan x=0..3, y=0..1.
  - wr_ready_out drops after value 7.
  - swap_out pulses and frame_count_out=1.
  - Output at address x+4y equals x+4y after 2 cycles (e.g. x=3, y=1 -> r=0, g=0, b=7).
- Out of bounds: x_in=4, y_in=0 and x_in=0, y_in=2 -> output BG_COLOR two cycles later.
  - With BG_COLOR=16'hF800: r=31, g=0, b=0.
- Upscale, SCALE_SHIFT=1: (x,y)=(2,0),(3,1) both read source pixel 1; (x,y)=(7,3) reads pixel 7; x=8 -> BG_COLOR.
- No tearing: write frame B (values 16'hFFFF) while displaying A, with frame_start_in pulsed mid-fill.
  - Output stays A; no swap_out.
  - After last and the next frame_start_in, output is 16'hFFFF (r=31, g=63, b=31).
- Short frame / auto-last: wr_last on the 3rd pixel -> FULL after 3 writes, and locations 3..7 keep old data.
  - Streaming 8 pixels without wr_last -> FULL after the 8th.
- Async reset mid-fill: assert rst_n_in=0 between clock edges after 5 writes.
  - Outputs read 0 immediately; wr_ready_out=1 after release; frame_count_out=0.
  - The next 8 writes start at address 0.
